// File: rtl/uart_word_transmitter.sv
// Sends a 32-bit word as four back-to-back UART frames, byte 0 first and LSB first.
// Defining UART_TX_PARITY_EN adds an even-parity bit after each data byte (8E1 framing).
`timescale 1ns/1ps

module uart_word_transmitter #(
    parameter int CLKS_PER_BIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] TxD_word_data,
    input  logic        TxD_word_start,
    output logic        TxD,
    output logic        TxD_busy,
    output logic        TxD_word_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bitEnd;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // The line value is computed one cycle ahead so TxD comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bitEnd   = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bitEnd ? '0 : baud_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                accept = TxD_word_start;
            end
            S_START: begin
                if (bitEnd) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bitEnd) begin
                    shift_d = {1'b0, shift_q[31:1]};
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_q ^ shift_q[0];
`endif
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q ^ shift_q[0];
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bitEnd) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bitEnd) begin
                    if (byte_q != 2'd3) begin
                        state_d = S_START;
                        byte_d  = byte_q + 2'd1;
                        txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = 1'b0;
`endif
                    end else begin
                        // A start request held through the final edge chains the next word gap-free.
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        accept  = TxD_word_start;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            byte_d  = '0;
            shift_d = TxD_word_data;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d = 1'b0;
`endif
        end
    end

    assign TxD           = txd_q;
    assign TxD_busy      = busy_q;
    assign TxD_word_done = done_q;

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Scoreboard bench for uart_word_transmitter: a line decoder and a done monitor check
// against expected words and completion times queued by the stimulus.
`timescale 1ns/1ps

module tb_uart_word_transmitter;

    localparam int CPB = 64;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int NBITS    = 4 * FRAME_BITS;
    localparam int WORD_CYC = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] TxD_word_data = '0;
    logic        TxD_word_start = 1'b0;
    logic        TxD;
    logic        TxD_busy;
    logic        TxD_word_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] expWords[$];
    int          expDone[$];

    uart_word_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .TxD_word_data(TxD_word_data),
        .TxD_word_start(TxD_word_start),
        .TxD(TxD),
        .TxD_busy(TxD_busy),
        .TxD_word_done(TxD_word_done)
    );

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference framing: per byte a 0 start bit, data LSB first, optional even parity, 1 stop bit.
    function automatic logic [43:0] frameBits(input logic [31:0] w);
        logic [43:0] f;
        logic [7:0]  b;
        int          p;
        f = '0;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            f[p] = 1'b0;
            p++;
            for (int j = 0; j < 8; j++) begin
                f[p] = b[j];
                p++;
            end
`ifdef UART_TX_PARITY_EN
            f[p] = ^b;
            p++;
`endif
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic expTxd, input logic expBusy,
                               input logic expDone);
        total++;
        if (TxD !== expTxd || TxD_busy !== expBusy || TxD_word_done !== expDone) begin
            bad++;
            $display("[TB] FAIL %s: TxD/busy/done got %b%b%b expected %b%b%b", name,
                     TxD, TxD_busy, TxD_word_done, expTxd, expBusy, expDone);
        end
    endtask

    // Pulses start for one cycle from idle; the expected word is queued only if it should complete.
    task automatic applyStimulus(input logic [31:0] w, input bit completes);
        @(negedge clk);
        TxD_word_data  = w;
        TxD_word_start = 1'b1;
        @(negedge clk);
        TxD_word_start = 1'b0;
        if (completes) begin
            expWords.push_back(w);
            expDone.push_back(cyc + WORD_CYC);
        end
        checkOutput("accept_next_cycle", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (TxD_word_done !== 1'b1 && n < budget);
        if (TxD_word_done !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    // Line decoder: every cycle of each bit slot must hold the slot's value.
    initial begin : decoder
        logic [43:0] got;
        logic [31:0] w;
        logic        glitch;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (!rst && TxD === 1'b0) begin
                got = '0;
                glitch = 1'b0;
                aborted = 1'b0;
                for (int s = 0; s < NBITS && !aborted; s++) begin
                    for (int k = 0; k < CPB && !aborted; k++) begin
                        if (s != 0 || k != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (k == 0) got[s] = TxD;
                        else if (TxD !== got[s]) glitch = 1'b1;
                    end
                end
                if (!aborted) begin
                    total++;
                    if (expWords.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL frame: unexpected frame bits %h", got);
                    end else begin
                        w = expWords.pop_front();
                        if (got !== frameBits(w) || glitch) begin
                            bad++;
                            $display("[TB] FAIL frame: got bits %h glitch=%b expected %h (word %h)",
                                     got, glitch, frameBits(w), w);
                        end
                    end
                end
            end
        end
    end

    initial begin : doneMonitor
        int e;
        forever begin
            @(negedge clk);
            if (TxD_word_done === 1'b1) begin
                total++;
                if (expDone.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL done: unexpected pulse at cycle %0d", cyc);
                end else begin
                    e = expDone.pop_front();
                    if (cyc != e) begin
                        bad++;
                        $display("[TB] FAIL done: pulse at cycle %0d expected %0d", cyc, e);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        // Reset and idle line
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checkOutput("reset_idle", 1'b1, 1'b0, 1'b0);
        end

        // Single known word
        applyStimulus(32'hA5C30F81, 1'b1);
        waitDone("single_word", WORD_CYC + 10);
        repeat (3) @(negedge clk);
        checkOutput("idle_after_word", 1'b1, 1'b0, 1'b0);

        // Start held high: two words chained with no idle gap
        @(negedge clk);
        TxD_word_data  = 32'h00000000;
        TxD_word_start = 1'b1;
        @(negedge clk);
        TxD_word_data = 32'hFFFFFFFF;
        c0 = cyc;
        expWords.push_back(32'h00000000);
        expWords.push_back(32'hFFFFFFFF);
        expDone.push_back(c0 + WORD_CYC);
        expDone.push_back(c0 + 2 * WORD_CYC);
        checkOutput("held_accept", 1'b0, 1'b1, 1'b0);
        while (cyc < c0 + 2 * WORD_CYC - 1) @(negedge clk);
        TxD_word_start = 1'b0;
        waitDone("held_second", 10);
        repeat (3) @(negedge clk);
        checkOutput("idle_after_chain", 1'b1, 1'b0, 1'b0);

        // Start while busy is ignored
        applyStimulus($urandom, 1'b1);
        repeat (300) @(negedge clk);
        TxD_word_data  = 32'h12345678;
        TxD_word_start = 1'b1;
        @(negedge clk);
        TxD_word_start = 1'b0;
        repeat (1700) @(negedge clk);
        TxD_word_start = 1'b1;
        @(negedge clk);
        TxD_word_start = 1'b0;
        waitDone("busy_ignore", WORD_CYC);
        repeat (200) @(negedge clk);
        checkOutput("idle_after_ignore", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset inside byte 2 data
        applyStimulus($urandom, 1'b0);
        repeat ((2 * FRAME_BITS + 3) * CPB) @(negedge clk);
        @(posedge clk);
        #0.5 rst = 1'b1;
        #0.2 checkOutput("async_reset", 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("idle_after_reset", 1'b1, 1'b0, 1'b0);
        applyStimulus(32'hDEADBEEF, 1'b1);
        waitDone("after_reset_word", WORD_CYC + 10);

        // Random words with random idle gaps
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom, 1'b1);
            waitDone("random_word", WORD_CYC + 10);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        total++;
        if (expWords.size() != 0 || expDone.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: words left %0d done left %0d expected 0 0",
                     expWords.size(), expDone.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
